// File: rtl/datapath_gen.sv
// Datapath generator: register file, ALU with flags, PC/LR/IR, a serial
// shift-add multiplier and a scan chain over {Flags, LR, Ir, PC}.
module datapath_gen #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RSW = $clog2(NREGS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    output logic [WIDTH-1:0] Ir,
    output logic [3:0]       Flags,
    input  logic [RSW-1:0]   Rs1,
    input  logic [RSW-1:0]   Rs2,
    input  logic [RSW-1:0]   Rw,
    input  logic             RegWe,
    input  logic             AluWe,
    input  logic             IrWe,
    input  logic             PcWe,
    input  logic             LrWe,
    input  logic             MemEn,
    input  logic [2:0]       AluOp,
    input  logic [1:0]       Op2Sel,
    input  logic [1:0]       PcSel,
    input  logic             WdSel,
    input  logic             MulStart,
    output logic             Busy,
    output logic             MulDone,
    input  logic             Test,
    input  logic             SDI,
    output logic             SDO,
    output logic             DbgMulState
);

    // Multiplier FSM states.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 3 * WIDTH + 4;

    logic [WIDTH-1:0] regFile [NREGS];
    logic [WIDTH-1:0] pc, lr;
    logic [WIDTH-1:0] rdA, rdB, opB, aluRes, wrData;
    logic [3:0]       aluFlags;
    logic [WIDTH:0]   sumAdd, sumSub;

    logic [0:0]       mulState;
    logic [CW-1:0]    mulCnt;
    logic [WIDTH-1:0] mulAcc, mulMcand, mulMplier;
    logic [RSW-1:0]   mulRw;
    logic             mulFinish;

    logic [SW-1:0]    scanCur, scanNext;

    // Combinational register reads; R0 is hard-wired to zero.
    assign rdA = (Rs1 == '0) ? '0 : regFile[Rs1];
    assign rdB = (Rs2 == '0) ? '0 : regFile[Rs2];

    assign DataOut     = MemEn ? rdB : '0;
    assign SDO         = pc[0];
    assign DbgMulState = mulState;
    assign wrData      = WdSel ? DataIn : aluRes;
    assign mulFinish   = (mulState == RUN) && (mulCnt == CW'(WIDTH));

    assign scanCur  = {Flags, lr, Ir, pc};
    assign scanNext = {SDI, scanCur[SW-1:1]};

    // Operand-B selection.
    always_comb begin
        opB = rdB;
        case (Op2Sel)
            2'd0:    opB = rdB;
            2'd1:    opB = {{(WIDTH-8){Ir[7]}}, Ir[7:0]};
            2'd2:    opB = pc;
            default: opB = WIDTH'(1);
        endcase
    end

    assign sumAdd = {1'b0, rdA} + {1'b0, opB};
    assign sumSub = {1'b0, rdA} - {1'b0, opB};

    // ALU result plus carry/overflow; Z and N are derived from the result.
    always_comb begin
        logic c, v;
        aluRes = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (AluOp)
            3'd0: begin
                aluRes = sumAdd[WIDTH-1:0];
                c      = sumAdd[WIDTH];
                v      = (rdA[WIDTH-1] == opB[WIDTH-1]) && (aluRes[WIDTH-1] != rdA[WIDTH-1]);
            end
            3'd1: begin
                aluRes = sumSub[WIDTH-1:0];
                c      = sumSub[WIDTH];  // borrow == A < B unsigned
                v      = (rdA[WIDTH-1] != opB[WIDTH-1]) && (aluRes[WIDTH-1] != rdA[WIDTH-1]);
            end
            3'd2: aluRes = rdA & opB;
            3'd3: aluRes = rdA | opB;
            3'd4: aluRes = rdA ^ opB;
            3'd5: aluRes = ~rdA;
            3'd6: begin
                aluRes = {rdA[WIDTH-2:0], 1'b0};
                c      = rdA[WIDTH-1];
            end
            default: begin
                aluRes = {1'b0, rdA[WIDTH-1:1]};
                c      = rdA[0];
            end
        endcase
        aluFlags = {(aluRes == '0), aluRes[WIDTH-1], c, v};
    end

    // PC, LR, IR and Flags; in test mode they form one shift register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc    <= '0;
            lr    <= '0;
            Ir    <= '0;
            Flags <= '0;
        end else if (Test) begin
            {Flags, lr, Ir, pc} <= scanNext;
        end else begin
            if (PcWe) begin
                case (PcSel)
                    2'd0:    pc <= pc + WIDTH'(1);
                    2'd1:    pc <= aluRes;
                    2'd2:    pc <= lr;
                    default: pc <= DataIn;
                endcase
            end
            if (LrWe)  lr    <= pc + WIDTH'(1);
            if (IrWe)  Ir    <= DataIn;
            if (AluWe) Flags <= aluFlags;
        end
    end

    // Register file writes; the multiplier result overrides a same-index write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
        end else if (!Test) begin
            if (RegWe && (Rw != '0)) regFile[Rw] <= wrData;
            if (mulFinish && (mulRw != '0)) regFile[mulRw] <= mulAcc;
        end
    end

    // Shift-add multiplier: WIDTH steps, then one completion cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mulState  <= IDLE;
            mulCnt    <= '0;
            mulAcc    <= '0;
            mulMcand  <= '0;
            mulMplier <= '0;
            mulRw     <= '0;
            Busy      <= 1'b0;
            MulDone   <= 1'b0;
        end else if (!Test) begin
            MulDone <= 1'b0;
            case (mulState)
                IDLE: begin
                    if (MulStart) begin
                        mulMcand  <= rdA;
                        mulMplier <= rdB;
                        mulRw     <= Rw;
                        mulAcc    <= '0;
                        mulCnt    <= '0;
                        mulState  <= RUN;
                    end
                end
                default: begin
                    if (mulCnt == CW'(WIDTH)) begin
                        MulDone  <= 1'b1;
                        Busy     <= 1'b0;
                        mulState <= IDLE;
                    end else begin
                        Busy      <= 1'b1;
                        if (mulMplier[0]) mulAcc <= mulAcc + mulMcand;
                        mulMcand  <= {mulMcand[WIDTH-2:0], 1'b0};
                        mulMplier <= {1'b0, mulMplier[WIDTH-1:1]};
                        mulCnt    <= mulCnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_gen.sv
// Directed bench for datapath_gen (WIDTH=16, NREGS=8).
module tb_datapath_gen;

    logic        Clock, Reset;
    logic [15:0] DataIn, DataOut, Ir;
    logic [3:0]  Flags;
    logic [2:0]  Rs1, Rs2, Rw;
    logic        RegWe, AluWe, IrWe, PcWe, LrWe, MemEn;
    logic [2:0]  AluOp;
    logic [1:0]  Op2Sel, PcSel;
    logic        WdSel, MulStart, Busy, MulDone, Test, SDI, SDO, DbgMulState;

    int total = 0;
    int bad   = 0;

    datapath_gen #(.WIDTH(16), .NREGS(8)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DataOut(DataOut),
        .Ir(Ir), .Flags(Flags), .Rs1(Rs1), .Rs2(Rs2), .Rw(Rw),
        .RegWe(RegWe), .AluWe(AluWe), .IrWe(IrWe), .PcWe(PcWe), .LrWe(LrWe),
        .MemEn(MemEn), .AluOp(AluOp), .Op2Sel(Op2Sel), .PcSel(PcSel),
        .WdSel(WdSel), .MulStart(MulStart), .Busy(Busy), .MulDone(MulDone),
        .Test(Test), .SDI(SDI), .SDO(SDO), .DbgMulState(DbgMulState)
    );

    // Clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearCtl();
        RegWe = 0; AluWe = 0; IrWe = 0; PcWe = 0; LrWe = 0; MemEn = 0;
        MulStart = 0; Test = 0; SDI = 0; WdSel = 0;
        AluOp = 0; Op2Sel = 0; PcSel = 0; Rs1 = 0; Rs2 = 0; Rw = 0; DataIn = 0;
    endtask

    task automatic loadReg(input logic [2:0] idx, input logic [15:0] val);
        RegWe = 1; WdSel = 1; Rw = idx; DataIn = val;
        tick();
        RegWe = 0; WdSel = 0;
    endtask

    task automatic readReg(input logic [2:0] idx, output logic [15:0] val);
        Rs2 = idx; MemEn = 1;
        #1;
        val = DataOut;
        MemEn = 0;
    endtask

    // PC is observed by routing 0 + PC through the ALU into R7.
    task automatic readPc(output logic [15:0] val);
        Rs1 = 0; Op2Sel = 2; AluOp = 0; WdSel = 0; Rw = 7; RegWe = 1;
        tick();
        RegWe = 0; Op2Sel = 0;
        readReg(7, val);
    endtask

    task automatic doAlu(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] sel, input logic [2:0] dst);
        AluOp = op; Rs1 = a; Rs2 = b; Op2Sel = sel; Rw = dst;
        AluWe = 1; RegWe = 1; WdSel = 0;
        tick();
        AluWe = 0; RegWe = 0; Op2Sel = 0;
    endtask

    logic [15:0] v;
    logic [51:0] pat, sOld, got;
    logic        doneSeen;

    initial begin
        clearCtl();
        Reset = 1;
        tick(); tick();
        Reset = 0;
        check("rst_ir", Ir, 16'h0);
        check("rst_flags", Flags, 4'h0);
        check("rst_busy", Busy, 1'b0);
        check("rst_muldone", MulDone, 1'b0);
        check("rst_sdo", SDO, 1'b0);
        check("rst_dataout_off", DataOut, 16'h0);
        readReg(1, v); check("rst_r1", v, 16'h0);

        // PC increment and wrap
        PcWe = 1; PcSel = 0;
        tick(); tick(); tick();
        PcWe = 0;
        check("pc3_sdo", SDO, 1'b1);
        readPc(v); check("pc_eq_3", v, 16'h0003);
        DataIn = 16'hFFFF; PcSel = 3; PcWe = 1;
        tick();
        check("pc_ffff_sdo", SDO, 1'b1);
        PcSel = 0;
        tick();
        PcWe = 0;
        readPc(v); check("pc_wrap", v, 16'h0000);

        // ALU and flags {Z,N,C,V}
        loadReg(1, 16'h7FFF);
        loadReg(2, 16'h0001);
        doAlu(0, 1, 2, 0, 3);
        check("add_flags", Flags, 4'b0101);
        readReg(3, v); check("add_r3", v, 16'h8000);
        doAlu(1, 2, 1, 0, 5);
        check("sub_flags", Flags, 4'b0110);
        readReg(5, v); check("sub_r5", v, 16'h8002);
        doAlu(2, 1, 2, 0, 6);
        check("and_flags", Flags, 4'b0000);
        readReg(6, v); check("and_r6", v, 16'h0001);
        doAlu(4, 1, 1, 0, 6);
        check("xor_flags", Flags, 4'b1000);
        doAlu(6, 3, 0, 0, 6);
        check("shl_flags", Flags, 4'b1010);
        readReg(6, v); check("shl_r6", v, 16'h0000);
        doAlu(7, 1, 0, 0, 6);
        check("shr_flags", Flags, 4'b0010);
        readReg(6, v); check("shr_r6", v, 16'h3FFF);
        doAlu(5, 1, 0, 0, 6);
        check("not_flags", Flags, 4'b0100);
        readReg(6, v); check("not_r6", v, 16'h8000);
        loadReg(6, 16'hFFFF);
        doAlu(0, 6, 0, 3, 6);
        check("inc_carry_flags", Flags, 4'b1010);
        readReg(6, v); check("inc_r6", v, 16'h0000);
        AluOp = 1; Rs1 = 2; Rs2 = 1; AluWe = 0;
        tick();
        check("flags_hold", Flags, 4'b1010);
        DataIn = 16'h0080; IrWe = 1;
        tick();
        IrWe = 0;
        check("ir_load", Ir, 16'h0080);
        doAlu(3, 0, 0, 1, 7);
        check("sext_flags", Flags, 4'b0100);
        readReg(7, v); check("sext_r7", v, 16'hFF80);

        // Multiply 300 * 200 into R4, with a late collision write and an ignored restart
        loadReg(1, 16'd300);
        loadReg(2, 16'd200);
        Rs1 = 1; Rs2 = 2; Rw = 4; MulStart = 1;
        tick();
        MulStart = 0;
        check("mul_state_run", DbgMulState, 1'b1);
        for (int e = 1; e <= 17; e++) begin
            if (e == 5)  begin MulStart = 1; Rs1 = 2; Rs2 = 2; Rw = 5; end
            if (e == 10) begin RegWe = 1; WdSel = 1; Rw = 6; DataIn = 16'h5555; end
            if (e == 17) begin RegWe = 1; WdSel = 1; Rw = 4; DataIn = 16'h1111; end
            tick();
            MulStart = 0; RegWe = 0; WdSel = 0;
            check($sformatf("mul_busy_e%0d", e), Busy, (e <= 16));
            check($sformatf("mul_done_e%0d", e), MulDone, (e == 17));
        end
        readReg(4, v); check("mul_r4", v, 16'hEA60);
        readReg(5, v); check("mul_restart_ignored", v, 16'h8002);
        readReg(6, v); check("mul_run_regwrite", v, 16'h5555);
        check("mul_flags_kept", Flags, 4'b0100);
        tick();
        check("mul_done_pulse_end", MulDone, 1'b0);
        loadReg(0, 16'hABCD);
        readReg(0, v); check("r0_zero", v, 16'h0000);

        // Scan chain
        DataIn = 16'h00A5; PcSel = 3; PcWe = 1;
        tick();
        PcWe = 0; LrWe = 1;
        tick();
        LrWe = 0; DataIn = 16'h1234; IrWe = 1;
        tick();
        IrWe = 0;
        AluOp = 1; Rs1 = 0; Op2Sel = 3; AluWe = 1;
        tick();
        AluWe = 0; Op2Sel = 0;
        check("scan_pre_flags", Flags, 4'b0110);
        sOld = {4'b0110, 16'h00A6, 16'h1234, 16'h00A5};
        pat  = 52'hCBEEF13579ACE;
        Test = 1; RegWe = 1; WdSel = 1; Rw = 6; DataIn = 16'hDEAD; IrWe = 1;
        for (int i = 0; i < 52; i++) begin
            got[i] = SDO;
            SDI = pat[i];
            tick();
        end
        Test = 0; RegWe = 0; WdSel = 0; IrWe = 0; SDI = 0;
        check("scan_out", got, sOld);
        check("scan_ir", Ir, 16'h1357);
        check("scan_flags", Flags, 4'hC);
        readReg(6, v); check("scan_regwe_blocked", v, 16'h5555);
        readPc(v); check("scan_pc", v, 16'h9ACE);
        PcSel = 2; PcWe = 1;
        tick();
        PcWe = 0;
        readPc(v); check("scan_lr", v, 16'hBEEF);

        // Multiplier freezes while Test=1
        Rs1 = 1; Rs2 = 2; Rw = 6; MulStart = 1;
        tick();
        MulStart = 0;
        for (int e = 1; e <= 21; e++) begin
            Test = (e >= 6 && e <= 9);
            tick();
            check($sformatf("frz_busy_e%0d", e), Busy, (e <= 20));
            check($sformatf("frz_done_e%0d", e), MulDone, (e == 21));
        end
        Test = 0;
        readReg(6, v); check("frz_r6", v, 16'hEA60);

        // Reset aborts a running multiply
        Rs1 = 1; Rs2 = 2; Rw = 4; MulStart = 1;
        tick();
        MulStart = 0;
        for (int i = 0; i < 5; i++) tick();
        Reset = 1;
        tick();
        Reset = 0;
        check("abort_busy", Busy, 1'b0);
        check("abort_done", MulDone, 1'b0);
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            doneSeen |= MulDone;
        end
        check("abort_no_done", doneSeen, 1'b0);
        readReg(4, v); check("abort_r4", v, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_gen.md
DATAPATH_GEN -- requirements
Module: datapath_gen

Interface
REQ-001 Parameter WIDTH, default 16, datapath word width (>=8).
REQ-002 Parameter NREGS, default 8, register-file depth (power of 2, >=4); RSW = log2(NREGS).
REQ-003 Clock  in  1  sole clock, all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 DataIn  in  WIDTH  memory read data.
REQ-006 DataOut  out  WIDTH  memory write data.
REQ-007 Ir  out  WIDTH  instruction register.
REQ-008 Flags  out  4  {Z,N,C,V}, bit 3 = Z.
REQ-009 Rs1, Rs2, Rw  in  RSW each  read-port-1, read-port-2 and write register indices.
REQ-010 RegWe, AluWe, IrWe, PcWe, LrWe, MemEn  in  1 each  write/drive enables.
REQ-011 AluOp  in  3  ALU operation.
REQ-012 Op2Sel  in  2  ALU operand-B select.
REQ-013 PcSel  in  2  PC next-value select.
REQ-014 WdSel  in  1  register write-data select.
REQ-015 MulStart  in  1  start multiply.
REQ-016 Busy, MulDone  out  1 each  multiplier status.
REQ-017 Test, SDI  in  1 each; SDO  out  1  scan enable, scan data in, scan data out.

Function
REQ-018 Register file: NREGS x WIDTH; R0 SHALL read zero and ignore writes; reads combinational; read-during-write returns old value.
REQ-019 Operand A = R[Rs1]; operand B per Op2Sel: 0 R[Rs2], 1 sign-extended Ir[7:0], 2 PC, 3 constant 1.
REQ-020 AluOp: 0 A+B, 1 A-B, 2 A&B, 3 A|B, 4 A^B, 5 ~A, 6 A<<1, 7 A>>1 logical; result truncated to WIDTH.
REQ-021 Flags SHALL update only when AluWe=1: Z=(result==0), N=result[WIDTH-1].
REQ-022 C: carry-out for ADD; 1 if A<B unsigned for SUB; A[WIDTH-1] for SHL; A[0] for SHR; 0 otherwise.
REQ-023 V: two's-complement overflow for ADD/SUB; 0 otherwise.
REQ-024 RegWe=1 writes R[Rw] with WdSel=0 ALU result, WdSel=1 DataIn.
REQ-025 IrWe=1 loads Ir from DataIn; LrWe=1 loads LR with PC+1.
REQ-026 PcWe=1 loads PC per PcSel: 0 PC+1 (wraps modulo 2^WIDTH), 1 ALU result, 2 LR, 3 DataIn.
REQ-027 DataOut = MemEn ? R[Rs2] : 0, combinational.
REQ-028 Multiplier states IDLE/RUN; MulStart in IDLE latches A=R[Rs1], B=R[Rs2] and Rw, enters RUN, asserts Busy next cycle.
REQ-029 RUN performs one shift-add step per cycle for WIDTH cycles; on the last step the low WIDTH product bits are written to the latched Rw and MulDone pulses for exactly one cycle, in the cycle after the last step; Busy falls in the same cycle.
REQ-030 MulDone SHALL assert exactly WIDTH+1 rising edges after the MulStart edge.
REQ-031 MulStart while Busy=1 is ignored; multiply never changes Flags.
REQ-032 Normal RegWe writes are allowed during RUN; when they collide with the multiplier result write to the same index, the multiplier write wins; a latched Rw of 0 discards the result.
REQ-033 Test=1: scan chain S = {Flags, LR, Ir, PC} (3*WIDTH+4 bits) shifts S <= {SDI, S[top:1]} each cycle; SDO = PC[0] at all times.
REQ-034 While Test=1, all other state writes are suppressed and the multiplier freezes, resuming unchanged when Test=0.

Reset
REQ-035 Reset=1 SHALL clear PC, Ir, LR, Flags, all registers, Busy and MulDone to 0, taking priority over Test and all enables.
REQ-036 Reset during RUN aborts the multiply with no register write and no MulDone.

Verification
REQ-037 Reset, then PcWe=1, PcSel=0 for 3 cycles -> PC=3; PC=0xFFFF with PC+1 -> PC=0x0000.
REQ-038 R1=0x7FFF, R2=0x0001, ADD with AluWe, RegWe to R3 -> R3=0x8000, Flags Z=0 N=1 C=0 V=1; SUB R2-R1 -> C=1.
REQ-039 R1=300, R2=200, MulStart, Rw=4 -> Busy for 16 cycles, MulDone at edge 17, R4=0xEA60; second MulStart mid-run ignored.
REQ-040 RegWe to R4 on the multiply completion cycle -> R4 holds product; write to R0 -> R0 reads 0.
REQ-041 Test=1 for 3*WIDTH+4 cycles shifting a known pattern -> SDO reproduces prior {Flags, LR, Ir, PC} LSB-first, new pattern loaded.
REQ-042 Reset asserted 5 cycles into a multiply -> Busy=0, no MulDone, destination register 0.
